// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: walks an LFSR challenge sequence through a 32-bit arbiter PUF and emits one (challenge, response) pair per step.
// Latency: LOAD->OUT is 4+SETTLE_CYC cycles per pair, or 3*SETTLE_CYC+8 when PUF_MAJORITY_VOTE_EN votes three evaluations.
// Backpressure: OUT holds resp_valid/resp_data/resp_chal and c_bits until resp_ready; no PUF activity while stalled.
module puf_crp_sequencer #(
    parameter int unsigned NUM_CRP    = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    output logic [31:0] c_bits,
    output logic        puf_en,
    input  logic [31:0] puf_resp,
    output logic [31:0] resp_data,
    output logic [31:0] resp_chal,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXCITE,
        S_SETTLE,
        S_SAMPLE,
        S_VOTE,
        S_OUT,
        S_DONE
    } state_t;

    // Settle down-counter only needs to hold SETTLE_CYC-1
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [15:0]   CRP_LAST    = 16'(NUM_CRP - 1);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [1:0] EVALS = 2'd3;
`else
    localparam logic [1:0] EVALS = 2'd1;
`endif

    state_t        state_q;
    logic [31:0]   chal_q;
    logic [31:0]   resp_data_q;
    logic [31:0]   resp_chal_q;
    logic [15:0]   crp_cnt_q;
    logic [1:0]    eval_cnt_q;
    logic [SW-1:0] settle_cnt_q;
    logic [31:0]   samp0_q;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [31:0]   samp1_q;
    logic [31:0]   samp2_q;
`endif
    logic          puf_en_q;
    logic          resp_valid_q;
    logic          busy_q;
    logic          done_q;

    logic [31:0]   lfsr_d;
    logic [31:0]   seed_d;
    logic [31:0]   vote_d;
    logic [1:0]    eval_inc_d;

    // x^32+x^22+x^2+x+1 Fibonacci step; maximal length, so a nonzero state never maps to zero
    assign lfsr_d     = {chal_q[30:0], chal_q[31] ^ chal_q[21] ^ chal_q[1] ^ chal_q[0]};
    // All-zero is the LFSR lock-up state, so a zero seed is promoted to 1
    assign seed_d     = (seed == 32'd0) ? 32'd1 : seed;
    assign eval_inc_d = eval_cnt_q + 2'd1;

`ifdef PUF_MAJORITY_VOTE_EN
    assign vote_d = (samp0_q & samp1_q) | (samp0_q & samp2_q) | (samp1_q & samp2_q);
`else
    assign vote_d = samp0_q;
`endif

    // Sequencer FSM; every output is a register updated on the transition into the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            chal_q       <= 32'd0;
            resp_data_q  <= 32'd0;
            resp_chal_q  <= 32'd0;
            crp_cnt_q    <= 16'd0;
            eval_cnt_q   <= 2'd0;
            settle_cnt_q <= '0;
            samp0_q      <= 32'd0;
`ifdef PUF_MAJORITY_VOTE_EN
            samp1_q      <= 32'd0;
            samp2_q      <= 32'd0;
`endif
            puf_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chal_q    <= seed_d;
                        crp_cnt_q <= 16'd0;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    eval_cnt_q <= 2'd0;
                    puf_en_q   <= 1'b1;
                    state_q    <= S_EXCITE;
                end
                S_EXCITE: begin
                    puf_en_q     <= 1'b0;
                    settle_cnt_q <= SETTLE_LAST;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                    case (eval_cnt_q)
                        2'd0:    samp0_q <= puf_resp;
                        2'd1:    samp1_q <= puf_resp;
                        default: samp2_q <= puf_resp;
                    endcase
`else
                    samp0_q <= puf_resp;
`endif
                    eval_cnt_q <= eval_inc_d;
                    if (eval_inc_d < EVALS) begin
                        puf_en_q <= 1'b1;
                        state_q  <= S_EXCITE;
                    end else begin
                        state_q  <= S_VOTE;
                    end
                end
                S_VOTE: begin
                    resp_data_q  <= vote_d;
                    resp_chal_q  <= chal_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_OUT;
                end
                S_OUT: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (crp_cnt_q == CRP_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            crp_cnt_q <= crp_cnt_q + 16'd1;
                            chal_q    <= lfsr_d;
                            state_q   <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The challenge register drives the PUF directly, so it is stable from LOAD through OUT
    assign c_bits     = chal_q;
    assign puf_en     = puf_en_q;
    assign resp_data  = resp_data_q;
    assign resp_chal  = resp_chal_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
